stage_reg_pipe: RTL and testbench
=================================

# stage_reg_pipe

Parametrised pipeline stage register with valid/ready handshake, flush-to-bubble and an optional two-entry skid buffer. Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and replaces the fixed-field per-stage registers. Stalls propagate by back-pressure instead of ad-hoc hold logic. Flushed slots turn into bubbles whose retained fields, such as next-PC, are selected by a mask.

## Interface
- WIDTH, 160, payload width in bits (default = 5 × 32-bit words)
- KEEP_MASK, {WIDTH{1'b0}}, payload bits copied from in_data into the bubble on flush; all other bits are forced to 0
- clk  in  1  clock; all state updates on the falling edge, matching the existing stage registers
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  discard all held and incoming data; present a bubble
- in_valid  in  1  upstream data valid
- in_ready  out  1  this block can accept in_data
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  out_data holds a real instruction slot
- out_ready  in  1  downstream accepts out_data
- out_data  out  WIDTH  payload, or bubble value when out_valid=0
- occupancy  out  2  number of valid entries held (0–2)

## Operation
- Two slots: MAIN drives out_data/out_valid; SKID catches one beat when the downstream stalls while in_ready is high.
- Accept = in_valid & in_ready; Issue = out_valid & out_ready.
- States follow occupancy:
  - EMPTY (0)
    - Accept → ONE: MAIN←in_data.
  - ONE (1)
    - Accept & Issue → ONE: MAIN←in_data.
    - Accept & !Issue → FULL: SKID←in_data.
    - Issue only → EMPTY.
  - FULL (2)
    - Issue → ONE: MAIN←SKID.
    - Accept is impossible, because in_ready=0.
- in_ready = !(state==FULL). It is registered, with no combinational path from out_ready.
- Data order is strictly FIFO. Data is never duplicated or dropped except by flush.
- Flush, evaluated every edge with priority over all handshakes:
  - State → EMPTY.
  - MAIN data ← in_data & KEEP_MASK.
  - SKID is cleared.
  - The same-edge Accept is discarded and the same-edge Issue is ignored.
- A bubble has out_valid=0 and out_data=(upstream & KEEP_MASK). Downstream decodes all-zero instruction bits as NOP.
- While out_valid=0, out_data holds its last bubble value until the next load.
- Reset has priority over flush.
  - Reset values: out_valid=0, out_data=0, in_ready=1, occupancy=0, SKID cleared.
  - A reset mid-transfer loses all held data.

## Timing
- Latency: in_data is accepted on falling edge N and is on out_data after edge N with out_valid=1, i.e. one cycle.
- Throughput: one beat per cycle sustained while out_ready=1.
- With out_ready low, at most 2 beats are absorbed. in_ready drops on the edge the second beat is captured.
- in_ready recovers one edge after the first Issue from FULL.
- Flush takes effect at the edge it is sampled. out_valid=0 and in_ready=1 follow immediately after that edge.

## Configuration
- STAGE_REG_PIPE_SKID_EN defined: behaviour as above, with a two-entry skid and registered in_ready.
- Not defined:
  - Single MAIN slot only; occupancy ≤ 1.
  - in_ready = out_ready | !out_valid, which is combinational.
  - A FULL state does not exist.
  - Flush, reset and bubble rules are unchanged.

## Structure
- Shared package (ISA.v): `WORD width, default stage payload widths, and state encodings EMPTY/ONE/FULL as localparams.
- Sub-module stage_reg_slot: one WIDTH-bit data register plus valid bit, with load/clear/bubble controls on the falling edge and synchronous rst_n. MAIN and SKID are two instances of it. Without the macro, only MAIN is instantiated.
- Top-level contents: state/occupancy logic and output muxing.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, out_data=0, in_ready=1, occupancy=0; release → first beat appears 1 cycle later.
- Streaming: out_ready=1, beats 0x1..0x8 back-to-back → outputs 0x1..0x8 in order, one per cycle, in_ready constantly 1.
- Stall absorb: out_ready=0 while sending 0xA, 0xB, 0xC → occupancy 1 then 2, in_ready=0, 0xC held upstream; raise out_ready → outputs 0xA, 0xB, 0xC in order, no loss.
- Flush in FULL: occupancy=2, flush=1 with in_data=0xDEAD_xxxx and KEEP_MASK selecting the upper 16 bits → out_valid=0, out_data=0xDEAD_0000, occupancy=0, in_ready=1.
- Flush vs. reset/accept: flush=1 with in_valid=1 → the beat is discarded; rst_n=0 and flush=1 together → reset values, out_data=0.
- Macro off: repeat the stall test → only 1 beat is held; in_ready follows out_ready combinationally in the same cycle.

Source files
------------

// File: rtl/stage_reg_pipe_pkg.sv
// Shared types and widths for the stage_reg_pipe pipeline register.
// Occupancy states double as the occupancy count encoding.
package stage_reg_pipe_pkg;

  localparam int WORD        = 32;
  localparam int STAGE_WORDS = 5;
  localparam int STAGE_WIDTH = STAGE_WORDS * WORD;

  localparam int IF_ID_WIDTH  = 2 * WORD;
  localparam int ID_EX_WIDTH  = 5 * WORD;
  localparam int EX_MEM_WIDTH = 4 * WORD;
  localparam int MEM_WB_WIDTH = 3 * WORD;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/stage_reg_pipe_slot.sv
// One payload register plus valid bit; updates on the falling edge.
// Priority: reset > clear > bubble > load.
module stage_reg_slot
  import stage_reg_pipe_pkg::*;
#(
  parameter int WIDTH = STAGE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             bubble,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             valid_q;
  logic             valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (bubble) begin
      data_d  = d;
      valid_d = 1'b0;
    end else if (load) begin
      data_d  = d;
      valid_d = 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q     = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/stage_reg_pipe.sv
// Pipeline stage register with valid/ready, flush-to-bubble and
// optional skid slot (STAGE_REG_PIPE_SKID_EN); updates on falling edge.
module stage_reg_pipe
  import stage_reg_pipe_pkg::*;
#(
  parameter int               WIDTH     = STAGE_WIDTH,
  parameter logic [WIDTH-1:0] KEEP_MASK = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  occ_e             state_q;
  occ_e             state_d;
  logic             accept;
  logic             issue;
  logic             m_load;
  logic             m_bub;
  logic [WIDTH-1:0] m_d;
  logic [WIDTH-1:0] main_data;
  logic             main_valid;

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign accept    = in_valid & in_ready;
  assign issue     = out_valid & out_ready;

  stage_reg_slot #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (m_load),
    .bubble(m_bub),
    .clear (1'b0),
    .d     (m_d),
    .q     (main_data),
    .valid (main_valid)
  );

`ifdef STAGE_REG_PIPE_SKID_EN
  logic             s_load;
  logic             s_clr;
  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             in_ready_q;
  logic             in_ready_d;

  stage_reg_slot #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (s_load),
    .bubble(1'b0),
    .clear (s_clr),
    .d     (in_data),
    .q     (skid_data),
    .valid (skid_valid)
  );

  always_comb begin
    state_d = state_q;
    m_load  = 1'b0;
    m_bub   = 1'b0;
    m_d     = in_data;
    s_load  = 1'b0;
    s_clr   = 1'b0;
    if (flush) begin
      state_d = EMPTY;
      m_bub   = 1'b1;
      m_d     = in_data & KEEP_MASK;
      s_clr   = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            m_load  = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && issue) begin
            m_load = 1'b1;
          end else if (accept) begin
            s_load  = 1'b1;
            state_d = FULL;
          end else if (issue) begin
            // drained slot keeps its payload, only the valid drops
            m_bub   = 1'b1;
            m_d     = main_data;
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (issue) begin
            m_load  = 1'b1;
            m_d     = skid_data;
            s_clr   = 1'b1;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
`else
  assign in_ready = out_ready | ~out_valid;

  always_comb begin
    state_d = state_q;
    m_load  = 1'b0;
    m_bub   = 1'b0;
    m_d     = in_data;
    if (flush) begin
      state_d = EMPTY;
      m_bub   = 1'b1;
      m_d     = in_data & KEEP_MASK;
    end else if (accept) begin
      m_load  = 1'b1;
      state_d = ONE;
    end else if (issue) begin
      m_bub   = 1'b1;
      m_d     = main_data;
      state_d = EMPTY;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign occupancy = (state_q == ONE) ? 2'd1 : 2'd0;
`endif

endmodule

// File: tb/tb_stage_reg_pipe.sv
// Scoreboard bench for stage_reg_pipe; DUT updates on falling edge,
// inputs driven at posedge+1, outputs sampled before the next negedge.
module tb_stage_reg_pipe;

  localparam int          W    = 32;
  localparam logic [31:0] MASK = 32'hFFFF_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;

  logic [W-1:0]  exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            waits;

  always #5 clk = ~clk;

  stage_reg_pipe #(.WIDTH(W), .KEEP_MASK(MASK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat from a drive point; push expected when it is taken.
  task automatic beat(input logic [W-1:0] d, output int nw);
    bit done;
    done     = 1'b0;
    nw       = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!done) begin
      #3;
      if (in_ready) begin
        exp_q.push_back(d);
        done = 1'b1;
      end
      cyc();
      if (!done) begin
        nw++;
        if (nw > 20) begin
          n_checks++;
          n_fail++;
          $display("FAIL beat_timeout: data %h never accepted", d);
          done = 1'b1;
        end
      end
    end
  endtask

  // Monitor: every issue must match the oldest outstanding beat.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #3;
      if (rst_n && !flush && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got %h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data_order", out_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0055;
    out_ready = 1'b1;
    cyc();
    cyc();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_occupancy", {30'b0, occupancy}, 32'd0);

    rst_n = 1'b1;
    beat(32'h0000_0055, waits);
    in_valid = 1'b0;
    check("first_valid", {31'b0, out_valid}, 32'd1);
    check("first_data", out_data, 32'h0000_0055);
    cyc();

    // streaming
    for (int i = 1; i <= 8; i++) begin
      beat(i, waits);
      check("stream_no_wait", waits, 32'd0);
    end
    in_valid = 1'b0;
    cyc();
    cyc();
    check("stream_drained", exp_q.size(), 32'd0);

    // stall absorb
    out_ready = 1'b0;
    beat(32'hA, waits);
    check("stall_occ1", {30'b0, occupancy}, 32'd1);
`ifdef STAGE_REG_PIPE_SKID_EN
    beat(32'hB, waits);
    check("stall_occ2", {30'b0, occupancy}, 32'd2);
    check("stall_not_ready", {31'b0, in_ready}, 32'd0);
    in_data = 32'hC;
    cyc();
    cyc();
    check("stall_hold_occ", {30'b0, occupancy}, 32'd2);
    check("stall_hold_data", out_data, 32'hA);
    out_ready = 1'b1;
    beat(32'hC, waits);
    check("recover_wait", waits, 32'd1);
`else
    check("stall_not_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    #1;
    check("comb_ready_hi", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b0;
    #1;
    check("comb_ready_lo", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_data  = 32'hB;
    cyc();
    cyc();
    check("stall_hold_occ", {30'b0, occupancy}, 32'd1);
    check("stall_hold_data", out_data, 32'hA);
    out_ready = 1'b1;
    beat(32'hB, waits);
    check("recover_wait", waits, 32'd0);
`endif
    in_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    check("stall_drained", exp_q.size(), 32'd0);

    // flush while holding data
    out_ready = 1'b0;
    beat(32'h0000_00A1, waits);
`ifdef STAGE_REG_PIPE_SKID_EN
    beat(32'h0000_00B1, waits);
    check("pre_flush_occ", {30'b0, occupancy}, 32'd2);
`endif
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    #3;
    exp_q.delete();
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_data", out_data, 32'hDEAD_0000);
    check("flush_occ", {30'b0, occupancy}, 32'd0);
    check("flush_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    cyc();
    cyc();
    check("flush_bubble_hold", out_data, 32'hDEAD_0000);
    beat(32'h77, waits);
    in_valid = 1'b0;
    cyc();
    cyc();
    check("post_flush_drained", exp_q.size(), 32'd0);

    // flush discards a same-edge accept
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_acc_valid", {31'b0, out_valid}, 32'd0);
    check("flush_acc_data", out_data, 32'h1234_0000);
    cyc();

    // reset beats flush
    out_ready = 1'b0;
    beat(32'h99, waits);
    rst_n    = 1'b0;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    #3;
    exp_q.delete();
    cyc();
    check("rstfl_data", out_data, 32'd0);
    check("rstfl_valid", {31'b0, out_valid}, 32'd0);
    check("rstfl_occ", {30'b0, occupancy}, 32'd0);
    check("rstfl_ready", {31'b0, in_ready}, 32'd1);
    rst_n     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    cyc();
    check("rstfl_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
